jstk_spi_reader: RTL and testbench
==================================

Name: jstk_spi_reader

Overview:
SPI master that polls one Digilent PmodJSTK joystick once per frame and returns its 10-bit X/Y position and 3 button bits. It sits directly upstream of the paddle-movement logic, which turns joystick Y into a paddle position. One instance per joystick (j1_*, j2_*). The transfer is triggered by the rising edge of endofframe, and results are registered atomically with a one-cycle valid strobe.

Parameters:
CLK_DIV, 50, clk50M cycles per SCK half-period (default gives 500 kHz SCK)
CS_SETUP_CYC, 750, cycles from CS falling to first SCK edge (15 us)
BYTE_GAP_CYC, 500, idle cycles between bytes, with SCK low and CS held low (10 us)

Ports:
clk50M  in  1  system clock, 50 MHz; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  frame trigger, driven by endofframe; synchronous to clk50M; transfer starts on its rising edge
led  in  2  PmodJSTK LED control; sampled at transfer start
cs  out  1  SPI chip select, active low
sck  out  1  SPI clock, mode 0 (idle low)
mosi  out  1  master out, MSB first
miso  in  1  master in; registered on each SCK rising edge
x  out  10  joystick X, 0..1023
y  out  10  joystick Y, 0..1023
buttons  out  3  {stick_btn, btn2, btn1}
valid  out  1  one-cycle pulse when x/y/buttons update
busy  out  1  high from the start-edge cycle through the DONE cycle

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - cs=1, sck=0, mosi=0, x=0, y=0, buttons=0, valid=0, busy=0.
  - State returns to IDLE; the partial shift register is discarded.
  - After reset deasserts, a new start rising edge is required to begin a transfer.
- Start edge detect: register start_d; trig = start & ~start_d. start_d resets to 0.
- FSM states: IDLE, SETUP, SHIFT, GAP, DONE.
  - IDLE: on trig, latch led, load tx byte = {6'b100000, led}, clear byte_cnt and bit_cnt, set cs=0 and busy=1, then go to SETUP.
  - SETUP: count CS_SETUP_CYC cycles with sck=0, then go to SHIFT.
  - SHIFT: each bit is CLK_DIV cycles with sck=0, then CLK_DIV cycles with sck=1.
    - mosi = tx[7-bit_cnt] for the whole bit.
    - miso is shifted into rx (MSB first) on the cycle sck goes 0->1.
    - After bit 7's high phase, sck returns to 0, rx is stored to byte slot byte_cnt, and byte_cnt increments.
    - If byte_cnt was 4, go to DONE; otherwise go to GAP.
  - GAP: count BYTE_GAP_CYC cycles with sck=0, mosi=0 and cs=0. Load tx=8'h00 (bytes 1..4 send zeros), then go to SHIFT.
  - DONE: one cycle, then return to IDLE.
    - cs=1, valid=1, busy stays 1 during this cycle and drops to 0 in IDLE.
    - x = {byte1[1:0], byte0}, y = {byte3[1:0], byte2}, buttons = byte4[2:0]; the upper bits of byte1/3/4 are ignored.
- Outputs x/y/buttons hold their previous values throughout a transfer and change only in the DONE cycle. Consumers never see a mix of old and new fields.
- trig while busy is ignored (no queueing). trig in the DONE cycle is also ignored.
- Latency (defaults): CS low to valid = 750 + 5*8*2*50 + 4*500 = 6750 cycles, about 135 us; this fits inside vertical blanking.
- sck and cs are driven from registers (glitch-free). Counters are sized for their parameter values; no wrap occurs within a state.
- led changes mid-transfer have no effect on the current transfer.

Test Plan:
(Bench parameters: CLK_DIV=2, CS_SETUP_CYC=4, BYTE_GAP_CYC=3; SPI slave model returns 0x34, 0x02, 0xFF, 0x03, 0x05.)
- Basic read: led=2'b11, pulse start -> cs low 1 cycle after the edge; first sck rise after 4 setup cycles; mosi byte0 = 0x83, bytes 1..4 = 0x00; after valid, x=564 (0x234), y=1023, buttons=3'b101; valid high exactly 1 cycle.
- Timing: count 40 sck rising edges per transfer; sck high and low phases are each 2 cycles; GAP phases are 3 cycles with cs=0; cs rises in the DONE cycle; busy and cs are high in IDLE.
- Atomic hold: x=564 from the first read, second transfer with slave bytes 0x00, 0x00, 0x10, 0x00, 0x00 -> x stays 564 until the valid cycle, then x=0, y=16, buttons=0 in the same cycle.
- Retrigger: start edges during SETUP and during SHIFT -> no restart, exactly one valid, 40 sck edges total. Holding start high for 100 cycles -> one transfer only.
- Mid-transfer reset: assert reset_n=0 during byte 2 -> cs=1, sck=0, x/y/buttons=0 and valid=0 asynchronously. After release and a new start edge, a full correct transfer occurs (x=564).
- Boundary values: slave returns 0xFF, 0xFF, 0x00, 0xFC, 0xFF -> x=1023, y=0, buttons=3'b111 (upper bits ignored).

Source files
------------

// File: rtl/jstk_spi_reader.sv
// PmodJSTK SPI master: one 5-byte poll per start edge, returning X/Y
// and buttons with an atomic update and a one-cycle valid strobe.
module jstk_spi_reader #(
    parameter int CLK_DIV      = 50,
    parameter int CS_SETUP_CYC = 750,
    parameter int BYTE_GAP_CYC = 500
) (
    input  logic       clk50M,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] led,
    output logic       cs,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [2:0] buttons,
    output logic       valid,
    output logic       busy
);

    localparam int BIT_CYC = 2 * CLK_DIV;
    localparam int MAX_A   = (CS_SETUP_CYC > BYTE_GAP_CYC) ? CS_SETUP_CYC : BYTE_GAP_CYC;
    localparam int MAX_C   = (MAX_A > BIT_CYC) ? MAX_A : BIT_CYC;
    localparam int CW      = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_start_d;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit;
    logic [2:0]      r_byte;
    logic [7:0]      r_tx;
    logic [7:0]      r_rx;
    logic [7:0]      r_bytes [4];
    logic            r_cs;
    logic            r_sck;
    logic [9:0]      r_x;
    logic [9:0]      r_y;
    logic [2:0]      r_btn;
    logic            r_valid;
    logic            r_busy;

    logic            w_trig;
    logic            w_setup_end;
    logic            w_gap_end;
    logic            w_rise;
    logic            w_bit_end;
    logic            w_byte_end;

    assign w_trig      = start & ~r_start_d;
    assign w_setup_end = (r_cnt == CW'(CS_SETUP_CYC - 1));
    assign w_gap_end   = (r_cnt == CW'(BYTE_GAP_CYC - 1));
    assign w_rise      = (r_cnt == CW'(CLK_DIV - 1));
    assign w_bit_end   = (r_cnt == CW'(BIT_CYC - 1));
    assign w_byte_end  = w_bit_end & (r_bit == 3'd7);

    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_trig) w_next = S_SETUP;
            S_SETUP: if (w_setup_end) w_next = S_SHIFT;
            S_SHIFT: if (w_byte_end) w_next = (r_byte == 3'd4) ? S_DONE : S_GAP;
            S_GAP:   if (w_gap_end) w_next = S_SHIFT;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            r_start_d <= 1'b0;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_byte    <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            for (int i = 0; i < 4; i++) r_bytes[i] <= '0;
            r_cs      <= 1'b1;
            r_sck     <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_btn     <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_start_d <= start;
            r_valid   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_trig) begin
                        r_cs   <= 1'b0;
                        r_busy <= 1'b1;
                        r_tx   <= {6'b100000, led};
                        r_cnt  <= '0;
                        r_bit  <= '0;
                        r_byte <= '0;
                    end
                end
                S_SETUP: r_cnt <= w_setup_end ? '0 : r_cnt + 1'b1;
                S_SHIFT: begin
                    r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
                    if (w_rise) begin
                        r_sck <= 1'b1;
                        r_rx  <= {r_rx[6:0], miso};
                    end
                    if (w_bit_end) begin
                        r_sck <= 1'b0;
                        r_bit <= r_bit + 1'b1;
                    end
                    // Last byte goes straight to the outputs so all fields update together
                    if (w_byte_end) begin
                        r_byte <= r_byte + 1'b1;
                        if (r_byte == 3'd4) begin
                            r_cs    <= 1'b1;
                            r_valid <= 1'b1;
                            r_x     <= {r_bytes[1][1:0], r_bytes[0]};
                            r_y     <= {r_bytes[3][1:0], r_bytes[2]};
                            r_btn   <= r_rx[2:0];
                        end else begin
                            r_bytes[r_byte[1:0]] <= r_rx;
                        end
                    end
                end
                S_GAP: begin
                    r_tx  <= 8'h00;
                    r_cnt <= w_gap_end ? '0 : r_cnt + 1'b1;
                end
                S_DONE:  r_busy <= 1'b0;
                default: ;
            endcase
        end
    end

    assign mosi    = (r_state == S_SHIFT) ? r_tx[3'd7 - r_bit] : 1'b0;
    assign cs      = r_cs;
    assign sck     = r_sck;
    assign x       = r_x;
    assign y       = r_y;
    assign buttons = r_btn;
    assign valid   = r_valid;
    assign busy    = r_busy;

endmodule

// File: tb/tb_jstk_spi_reader.sv
// Directed bench for jstk_spi_reader: vector table of slave replies
// plus retrigger, held-start and mid-transfer reset sequences.
`timescale 1ns/1ps
module tb_jstk_spi_reader;

    logic       clk50M  = 1'b0;
    logic       reset_n = 1'b0;
    logic       start   = 1'b0;
    logic [1:0] led     = 2'b00;
    logic       miso;
    logic       cs, sck, mosi, valid, busy;
    logic [9:0] x, y;
    logic [2:0] buttons;

    always #5 clk50M = ~clk50M;

    jstk_spi_reader #(
        .CLK_DIV(2),
        .CS_SETUP_CYC(4),
        .BYTE_GAP_CYC(3)
    ) dut (
        .clk50M(clk50M),
        .reset_n(reset_n),
        .start(start),
        .led(led),
        .cs(cs),
        .sck(sck),
        .mosi(mosi),
        .miso(miso),
        .x(x),
        .y(y),
        .buttons(buttons),
        .valid(valid),
        .busy(busy)
    );

    typedef struct {
        logic [39:0] slv;
        logic [1:0]  led;
        logic [7:0]  mosi0;
        logic [9:0]  ex;
        logic [9:0]  ey;
        logic [2:0]  eb;
    } vec_t;

    vec_t vecs [4];
    int   total = 0;
    int   bad   = 0;
    int   tcase = 0;

    // Monitor / slave state; only the monitor writes these
    int          gen = 0, seen = 0, cyc = 0;
    int          rises = 0, cs_low = 0, cs_fall_t = -1, first_rise_t = -1;
    int          run = 0, hi_min = 999, hi_max = 0, lo_min = 999;
    int          valid_cnt = 0, chg_err = 0;
    logic [39:0] mcap = '0;
    logic [39:0] slv_bits = '0;
    logic [9:0]  vx = '0, vy = '0, prev_x = '0, prev_y = '0;
    logic [2:0]  vb = '0, prev_b = '0;
    logic        vcs = 1'b0, vbusy = 1'b0;
    logic        prev_sck = 1'b0, prev_cs = 1'b1, prev_rst = 1'b0;
    logic        miso_r = 1'b0;

    assign miso = miso_r;

    always @(negedge clk50M) begin
        int ri;
        logic [5:0] bi;
        if (gen != seen) begin
            seen = gen;
            rises = 0; cs_low = 0; cs_fall_t = -1; first_rise_t = -1;
            run = 0; hi_min = 999; hi_max = 0; lo_min = 999;
            valid_cnt = 0; chg_err = 0; mcap = '0;
        end
        cyc++;
        if (!cs) cs_low++;
        if (!cs && prev_cs && cs_fall_t < 0) cs_fall_t = cyc;
        if (sck != prev_sck) begin
            if (prev_sck) begin
                if (run < hi_min) hi_min = run;
                if (run > hi_max) hi_max = run;
            end else if (rises > 0) begin
                if (run < lo_min) lo_min = run;
            end
            run = 1;
        end else begin
            run++;
        end
        if (sck && !prev_sck) begin
            rises++;
            if (first_rise_t < 0) first_rise_t = cyc;
            mcap = {mcap[38:0], mosi};
        end
        if (valid) begin
            valid_cnt++;
            vx = x; vy = y; vb = buttons; vcs = cs; vbusy = busy;
        end
        if (!valid && reset_n && prev_rst &&
            (x != prev_x || y != prev_y || buttons != prev_b)) chg_err++;
        prev_sck = sck; prev_cs = cs; prev_rst = reset_n;
        prev_x = x; prev_y = y; prev_b = buttons;
        ri = (rises > 39) ? 39 : rises;
        bi = 6'(39 - ri);
        miso_r = slv_bits[bi];
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL case%0d %s: got %0h want %0h", tcase, nm, act, exp);
        end
    endtask

    task automatic wait_valid(input int lim);
        int n = 0;
        while (valid_cnt == 0 && n < lim) begin
            @(negedge clk50M); #1;
            n++;
        end
        chk("valid_seen", longint'(valid_cnt > 0), 1);
    endtask

    task automatic pulse_start();
        @(posedge clk50M); #2;
        start = 1'b1;
        @(posedge clk50M); #2;
        start = 1'b0;
    endtask

    task automatic run_xfer(input int i, input logic [9:0] px, input logic [9:0] py,
                            input logic [2:0] pb);
        @(posedge clk50M); #2;
        slv_bits = vecs[i].slv;
        led      = vecs[i].led;
        gen++;
        start    = 1'b1;
        @(posedge clk50M); #2;
        start    = 1'b0;
        led      = ~led;
        repeat (60) @(posedge clk50M);
        #3;
        chk("hold_x", x, px);
        chk("hold_y", y, py);
        chk("hold_b", buttons, pb);
        chk("busy_mid", busy, 1);
        wait_valid(400);
        repeat (3) @(negedge clk50M);
        #1;
    endtask

    task automatic check_xfer(input int i);
        chk("sck_rises", rises, 40);
        chk("sck_hi_min", hi_min, 2);
        chk("sck_hi_max", hi_max, 2);
        chk("sck_lo_min", lo_min, 2);
        chk("cs_low_cyc", cs_low, 176);
        chk("setup_lat", first_rise_t - cs_fall_t, 6);
        chk("mosi_bits", mcap, {vecs[i].mosi0, 32'h0});
        chk("valid_cnt", valid_cnt, 1);
        chk("x", vx, vecs[i].ex);
        chk("y", vy, vecs[i].ey);
        chk("buttons", vb, vecs[i].eb);
        chk("cs_in_done", vcs, 1);
        chk("busy_in_done", vbusy, 1);
        chk("atomic", chg_err, 0);
        chk("idle_busy", busy, 0);
        chk("idle_cs", cs, 1);
    endtask

    task automatic check_reset_vals();
        chk("rst_cs", cs, 1);
        chk("rst_sck", sck, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_b", buttons, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
    endtask

    initial begin
        int n;
        vecs[0] = '{slv: 40'h34_02_FF_03_05, led: 2'b11, mosi0: 8'h83,
                    ex: 10'd564, ey: 10'd1023, eb: 3'b101};
        vecs[1] = '{slv: 40'h00_00_10_00_00, led: 2'b00, mosi0: 8'h80,
                    ex: 10'd0, ey: 10'd16, eb: 3'b000};
        vecs[2] = '{slv: 40'hFF_FF_00_FC_FF, led: 2'b01, mosi0: 8'h81,
                    ex: 10'd1023, ey: 10'd0, eb: 3'b111};
        vecs[3] = '{slv: 40'h5A_01_A5_02_02, led: 2'b10, mosi0: 8'h82,
                    ex: 10'd346, ey: 10'd677, eb: 3'b010};

        repeat (3) @(posedge clk50M);
        #2;
        check_reset_vals();
        reset_n = 1'b1;
        repeat (5) @(posedge clk50M);
        #2;
        tcase = 1;
        check_reset_vals();

        for (int i = 0; i < 4; i++) begin
            tcase = 10 + i;
            if (i == 0) run_xfer(i, 10'd0, 10'd0, 3'd0);
            else        run_xfer(i, vecs[i-1].ex, vecs[i-1].ey, vecs[i-1].eb);
            check_xfer(i);
        end

        // Retrigger during SETUP and SHIFT must not restart
        tcase = 20;
        @(posedge clk50M); #2;
        slv_bits = vecs[0].slv;
        led = vecs[0].led;
        gen++;
        pulse_start();
        repeat (1) @(posedge clk50M);
        pulse_start();
        repeat (25) @(posedge clk50M);
        pulse_start();
        wait_valid(400);
        repeat (200) @(negedge clk50M);
        #1;
        chk("retrig_valid", valid_cnt, 1);
        chk("retrig_rises", rises, 40);
        chk("retrig_x", vx, vecs[0].ex);
        chk("retrig_b", vb, vecs[0].eb);

        // Start held high gives a single transfer
        tcase = 21;
        @(posedge clk50M); #2;
        slv_bits = vecs[2].slv;
        led = vecs[2].led;
        gen++;
        start = 1'b1;
        repeat (300) @(posedge clk50M);
        #2;
        start = 1'b0;
        repeat (20) @(negedge clk50M);
        #1;
        chk("hold_valid", valid_cnt, 1);
        chk("hold_rises", rises, 40);
        chk("hold_x_end", x, vecs[2].ex);
        chk("hold_y_end", y, vecs[2].ey);

        // Asynchronous reset in the middle of byte 2
        tcase = 22;
        @(posedge clk50M); #2;
        slv_bits = vecs[3].slv;
        led = vecs[3].led;
        gen++;
        pulse_start();
        n = 0;
        while (rises < 20 && n < 300) begin
            @(negedge clk50M); #1;
            n++;
        end
        chk("reach_byte2", longint'(rises >= 20), 1);
        @(posedge clk50M); #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals();
        @(posedge clk50M); #2;
        reset_n = 1'b1;
        repeat (10) @(posedge clk50M);
        #2;
        chk("no_autostart_cs", cs, 1);
        chk("no_autostart_busy", busy, 0);
        tcase = 23;
        run_xfer(0, 10'd0, 10'd0, 3'd0);
        check_xfer(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
